// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the WB stage (A) and a queued long-latency unit (B).
// Optional feature: define WB_BYPASS_EN to let B write straight through when the port is idle.
module wb_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_we,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [4:0]      b_rd,
    input  logic [XLEN-1:0] b_data,
    input  logic [4:0]      chk_rd,
    output logic            chk_hit,
    output logic            stall_req,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    output logic            proto_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [SW-1:0] LIMIT      = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, PEND, FORCE, DRAIN} state_t;

    state_t          state, state_next;
    logic [4:0]      mem_rd   [DEPTH];
    logic [XLEN-1:0] mem_data [DEPTH];
    logic [PW-1:0]   head, tail;
    logic [CW-1:0]   count, count_next;
    logic [SW-1:0]   starve, starve_next;
    logic            full, empty, push, pop, bypass, proto_next;
    logic            sel_we;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign b_ready = !full;
`ifdef WB_BYPASS_EN
    assign bypass  = empty && !a_we && b_valid;
`else
    assign bypass  = 1'b0;
`endif
    assign push       = b_valid && !full && !bypass;
    assign pop        = !a_we && !empty;
    assign count_next = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[tail]   <= b_rd;
            mem_data[tail] <= b_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            count <= count_next;
        end
    end

    // Only live entries in [head, tail) are compared; the head being popped still counts.
    always_comb begin
        chk_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, PW'(i) - head} < count) && (mem_rd[i] == chk_rd) && (chk_rd != 5'd0))
                chk_hit = 1'b1;
        end
    end

    always_comb begin
        sel_we   = 1'b0;
        sel_rd   = '0;
        sel_data = '0;
        if (a_we) begin
            sel_we   = 1'b1;
            sel_rd   = a_rd;
            sel_data = a_data;
        end else if (pop) begin
            sel_we   = 1'b1;
            sel_rd   = mem_rd[head];
            sel_data = mem_data[head];
        end else if (bypass) begin
            sel_we   = 1'b1;
            sel_rd   = b_rd;
            sel_data = b_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= sel_we && (sel_rd != 5'd0);
            if (sel_we) begin
                rf_rd    <= sel_rd;
                rf_wdata <= sel_data;
            end
        end
    end

    // FORCE is the cycle stall_req is high; DRAIN is the bubble cycle that follows it.
    always_comb begin
        state_next  = state;
        starve_next = starve;
        proto_next  = proto_err;
        unique case (state)
            IDLE: begin
                if (push) state_next = PEND;
            end
            PEND: begin
                if (count_next == '0) begin
                    state_next  = IDLE;
                    starve_next = '0;
                end else if (pop) begin
                    starve_next = '0;
                end else if (a_we) begin
                    starve_next = starve + 1'b1;
                    if (starve_next == LIMIT) state_next = FORCE;
                end
            end
            FORCE: begin
                state_next = DRAIN;
                if (pop) starve_next = '0;
            end
            DRAIN: begin
                starve_next = '0;
                if (a_we) proto_next = 1'b1;
                state_next = (count_next == '0) ? IDLE : PEND;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            starve    <= '0;
            stall_req <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_next;
            starve    <= starve_next;
            stall_req <= (state_next == FORCE);
            proto_err <= proto_next;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic, all checked against
// a queue-based reference model of the write-port sharing rules.
module tb_wb_port_arbiter;

    localparam int XLEN         = 32;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            a_we = 1'b0;
    logic [4:0]      a_rd = '0;
    logic [XLEN-1:0] a_data = '0;
    logic            b_valid = 1'b0;
    logic            b_ready;
    logic [4:0]      b_rd = '0;
    logic [XLEN-1:0] b_data = '0;
    logic [4:0]      chk_rd = '0;
    logic            chk_hit;
    logic            stall_req;
    logic            rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wdata;
    logic            proto_err;

    wb_port_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .a_we(a_we), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .chk_rd(chk_rd), .chk_hit(chk_hit), .stall_req(stall_req),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t          q[$];
    int              lose;
    bit              m_stall, m_bubble, m_proto, m_rf_we;
    logic [4:0]      m_rf_rd;
    logic [XLEN-1:0] m_rf_wdata;
    int              vectors = 0;
    int              miscompares = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        q.delete();
        lose       = 0;
        m_stall    = 0;
        m_bubble   = 0;
        m_proto    = 0;
        m_rf_we    = 0;
        m_rf_rd    = '0;
        m_rf_wdata = '0;
    endtask

    task automatic compareOutputs();
        bit hit;
        hit = 0;
        foreach (q[i]) if (chk_rd != 5'd0 && q[i].rd == chk_rd) hit = 1;
        checkOutput("b_ready", b_ready, q.size() < DEPTH);
        checkOutput("chk_hit", chk_hit, hit);
        checkOutput("stall_req", stall_req, m_stall);
        checkOutput("proto_err", proto_err, m_proto);
        checkOutput("rf_we", rf_we, m_rf_we);
        if (m_rf_we) begin
            checkOutput("rf_rd", rf_rd, m_rf_rd);
            checkOutput("rf_wdata", rf_wdata, m_rf_wdata);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic modelStep();
        bit     queued, popped, do_push;
        entry_t e;
        queued  = (q.size() != 0);
        popped  = 0;
        do_push = b_valid && (q.size() < DEPTH);
        if (a_we) begin
            m_rf_we = (a_rd != 5'd0); m_rf_rd = a_rd; m_rf_wdata = a_data;
        end else if (queued) begin
            e = q.pop_front();
            popped = 1;
            m_rf_we = (e.rd != 5'd0); m_rf_rd = e.rd; m_rf_wdata = e.data;
`ifdef WB_BYPASS_EN
        end else if (b_valid) begin
            do_push = 0;
            m_rf_we = (b_rd != 5'd0); m_rf_rd = b_rd; m_rf_wdata = b_data;
`endif
        end else begin
            m_rf_we = 0;
        end
        if (do_push) begin
            e.rd = b_rd; e.data = b_data;
            q.push_back(e);
        end
        if (m_bubble && a_we) m_proto = 1;
        if (m_bubble) begin
            lose = 0;
            m_bubble = 0;
        end else if (m_stall) begin
            if (popped) lose = 0;
            m_stall  = 0;
            m_bubble = 1;
        end else if (!queued || popped) begin
            lose = 0;
        end else begin
            lose++;
            if (lose == STARVE_LIMIT) m_stall = 1;
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] ard, input logic [XLEN-1:0] adat,
                                 input logic bv, input logic [4:0] brd, input logic [XLEN-1:0] bdat,
                                 input logic [4:0] crd);
        @(negedge clk);
        a_we = we; a_rd = ard; a_data = adat;
        b_valid = bv; b_rd = brd; b_data = bdat;
        chk_rd = crd;
        #1;
        compareOutputs();
        modelStep();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset lands mid-cycle; outputs must clear before the next clock edge.
    task automatic resetDut();
        @(negedge clk);
        a_we = 0; a_rd = 0; a_data = 0; b_valid = 0; b_rd = 0; b_data = 0; chk_rd = 0;
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_rf_we", rf_we, 0);
        checkOutput("rst_rf_rd", rf_rd, 0);
        checkOutput("rst_rf_wdata", rf_wdata, 0);
        checkOutput("rst_stall_req", stall_req, 0);
        checkOutput("rst_proto_err", proto_err, 0);
        checkOutput("rst_b_ready", b_ready, 1);
        modelReset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic            r_we, r_bv;
        logic [4:0]      r_ard, r_brd, r_crd;
        logic [XLEN-1:0] r_adat, r_bdat;

        modelReset();
        resetDut();

        // Lone B result on an idle port
        applyStimulus(0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0);
        idle(3);

        // A busy every cycle: fill FIFO, probe scoreboard, then wait for the starvation stall
        for (int i = 1; i <= 4; i++)
            applyStimulus(1, 5'd10, 32'h0A0A_0000 + i, 1, 5'(i), 32'h100 + i, 0);
        applyStimulus(1, 5'd10, 32'h11, 0, 0, 0, 5'd3);
        applyStimulus(1, 5'd10, 32'h12, 0, 0, 0, 5'd7);
        applyStimulus(1, 5'd10, 32'h13, 0, 0, 0, 5'd0);
        for (int i = 0; i < 20 && !stall_req; i++) applyStimulus(1, 5'd11, $urandom, 0, 0, 0, 0);
        checkOutput("stall_seen", stall_req, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 5'd1);

        // Second stall ignored by A: protocol error, queue untouched
        for (int i = 0; i < 20 && !stall_req; i++) applyStimulus(1, 5'd12, $urandom, 0, 0, 0, 5'd2);
        checkOutput("stall_seen2", stall_req, 1);
        applyStimulus(1, 5'd12, 32'h5A5A_5A5A, 0, 0, 0, 0);
        applyStimulus(1, 5'd12, 32'h6B6B_6B6B, 0, 0, 0, 5'd4);
        idle(5);
        checkOutput("proto_sticky", proto_err, 1);

        // x0 writes are suppressed but still consume their slot
        resetDut();
        applyStimulus(1, 5'd0, 32'h1234, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 5'd0, 32'hBAD0, 0);
        applyStimulus(0, 0, 0, 1, 5'd9, 32'h9999, 5'd9);
        idle(4);

        // Reset with three entries queued
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 5'd13, 32'h77 + i, 1, 5'(20 + i), 32'hC0 + i, 0);
        resetDut();
        for (int r = 0; r < 32; r++) applyStimulus(0, 0, 0, 0, 0, 0, 5'(r));

        // Randomized traffic; the post-stall bubble is honoured most of the time
        for (int n = 0; n < 600; n++) begin
            r_we   = ($urandom_range(0, 99) < 75);
            if (m_bubble && $urandom_range(0, 9) != 0) r_we = 0;
            r_ard  = 5'($urandom_range(0, 31));
            r_adat = $urandom;
            r_bv   = ($urandom_range(0, 99) < 40);
            r_brd  = 5'($urandom_range(0, 7));
            r_bdat = $urandom;
            r_crd  = 5'($urandom_range(0, 7));
            applyStimulus(r_we, r_ard, r_adat, r_bv, r_brd, r_bdat, r_crd);
        end
        idle(8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
